// File: rtl/ap_stream_sequencer.sv
// ap_stream_sequencer
// Host-side job sequencer for the AP_s associative processor. One job:
// clear both internal banks, stream CELL_QUANT operand pairs into column B
// and column A, run the compute in ap_mode, wait for the AP completion
// interrupt, then stream column C back out on a valid/ready interface.
//
// Ports
//   CLK100MHZ, rst_n          clock, async active-low reset
//   start, cmd                job start pulse (IDLE only) and AP opcode
//   in_valid/in_ready/in_a/in_b   operand pair stream (A -> col 0, B -> col 1)
//   out_valid/out_ready/out_data  result stream from column C
//   busy, done, err           status: not idle, job end pulse, sticky error
//   ap_*                      AP-side control / data bus
//   ap_data_out, ap_state_irq AP read data and compute-finished level
//
// state    | meaning
// IDLE     | waiting for start
// CLR0     | clear internal bank 0
// CLR1     | clear internal bank 1
// WR_B     | waiting for an operand pair, B written the cycle after
// WR_A     | B write on the bus, queue the held A write
// COMPUTE  | ap_mode high, waiting for a fresh irq edge or timeout
// RD_ISSUE | read strobe for column C at idx
// RD_WAIT  | read latency
// RD_OUT   | result presented, waiting for out_ready
// DONE     | completion pulse
module ap_stream_sequencer #(
    parameter int WORD_SIZE      = 8,
    parameter int CELL_QUANT     = 512,
    parameter int ADDR_W         = $clog2(CELL_QUANT + 1),
    parameter int READ_LAT       = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           cmd,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_a,
    input  logic [WORD_SIZE-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_W-1:0]    ap_addr,
    output logic [WORD_SIZE-1:0] ap_data,
    output logic                 ap_rst,
    output logic                 ap_mode,
    output logic [2:0]           ap_cmd,
    output logic [1:0]           ap_sel_col,
    output logic                 ap_sel_internal_col,
    output logic                 ap_write_en,
    output logic                 ap_read_en,
    input  logic [WORD_SIZE-1:0] ap_data_out,
    input  logic                 ap_state_irq
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELL_QUANT - 1);

    typedef enum logic [3:0] {
        IDLE, CLR0, CLR1, WR_B, WR_A, COMPUTE, RD_ISSUE, RD_WAIT, RD_OUT, DONE
    } state_t;

    state_t               state;
    logic [ADDR_W-1:0]    idx;
    logic [WORD_SIZE-1:0] hold_a;
    logic [TW-1:0]        timer;
    logic [LW-1:0]        lat;
    logic                 irq_prev;
    logic                 mode_q;
    logic                 irq_rise;

    assign irq_rise = ap_state_irq & ~irq_prev;
    // mode must fall the instant reset is asserted, not only at the flop
    assign ap_mode  = mode_q & rst_n;

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            idx                 <= '0;
            hold_a              <= '0;
            timer               <= '0;
            lat                 <= '0;
            irq_prev            <= 1'b0;
            mode_q              <= 1'b0;
            in_ready            <= 1'b0;
            out_valid           <= 1'b0;
            out_data            <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
            ap_addr             <= '0;
            ap_data             <= '0;
            ap_rst              <= 1'b0;
            ap_cmd              <= 3'd0;
            ap_sel_col          <= 2'd0;
            ap_sel_internal_col <= 1'b0;
            ap_write_en         <= 1'b0;
            ap_read_en          <= 1'b0;
        end else begin
            irq_prev <= ap_state_irq;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cmd == 3'd7) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            ap_cmd              <= cmd;
                            err                 <= 1'b0;
                            busy                <= 1'b1;
                            ap_rst              <= 1'b1;
                            ap_sel_internal_col <= 1'b0;
                            state               <= CLR0;
                        end
                    end
                end
                CLR0: begin
                    ap_sel_internal_col <= 1'b1;
                    state               <= CLR1;
                end
                CLR1: begin
                    ap_rst              <= 1'b0;
                    ap_sel_internal_col <= 1'b0;
                    idx                 <= '0;
                    in_ready            <= 1'b1;
                    state               <= WR_B;
                end
                WR_B: begin
                    // in_ready is always high here, so in_valid is the handshake
                    if (in_valid) begin
                        hold_a      <= in_a;
                        ap_write_en <= 1'b1;
                        ap_sel_col  <= 2'd1;
                        ap_addr     <= idx;
                        ap_data     <= in_b;
                        in_ready    <= 1'b0;
                        state       <= WR_A;
                    end else begin
                        ap_write_en <= 1'b0;
                    end
                end
                WR_A: begin
                    // write strobe and address carry over; only column and data change
                    ap_sel_col <= 2'd0;
                    ap_data    <= hold_a;
                    if (idx == LAST) begin
                        timer <= TW'(TIMEOUT_CYCLES);
                        state <= COMPUTE;
                    end else begin
                        idx      <= idx + 1'b1;
                        in_ready <= 1'b1;
                        state    <= WR_B;
                    end
                end
                COMPUTE: begin
                    ap_write_en <= 1'b0;
                    if (irq_rise) begin
                        mode_q     <= 1'b0;
                        idx        <= '0;
                        ap_addr    <= '0;
                        ap_sel_col <= 2'd2;
                        ap_read_en <= 1'b1;
                        state      <= RD_ISSUE;
                    end else if (timer == '0) begin
                        mode_q <= 1'b0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        timer  <= timer - 1'b1;
                        mode_q <= 1'b1;
                    end
                end
                RD_ISSUE: begin
                    ap_read_en <= 1'b0;
                    lat        <= LW'(READ_LAT - 1);
                    state      <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (lat == '0) begin
                        out_data  <= ap_data_out;
                        out_valid <= 1'b1;
                        state     <= RD_OUT;
                    end else begin
                        lat <= lat - 1'b1;
                    end
                end
                RD_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx        <= idx + 1'b1;
                            ap_addr    <= idx + 1'b1;
                            ap_read_en <= 1'b1;
                            state      <= RD_ISSUE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
